add_operand_sequencer: RTL and testbench

Upstream issue stage for the team's combinational 32-bit CLA adder (inputs a, b, cin; outputs sum, overflow).
- Accepts ADD/SUB commands at 32 or 64 bits over a valid/ready handshake.
- Drives the adder one 32-bit word per cycle, converting SUB to a + ~b + 1.
- Recovers the carry-out that the adder does not provide, and chains it into the high word for 64-bit ops.
- Returns the assembled result, carry and signed overflow on a valid/ready result port.

---
 rtl/add_operand_sequencer_pkg.sv | 28 ++
 rtl/add_operand_sequencer_if.sv | 40 ++++
 rtl/add_operand_sequencer_carry_recover.sv | 10 +
 rtl/add_operand_sequencer.sv | 122 ++++++++++++
 tb/tb_add_operand_sequencer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/add_operand_sequencer_pkg.sv
// Shared types and helpers for the adder operand sequencer: op and state encodings and the word width.
package add_seq_pkg;

  localparam int W = 32;

  typedef enum logic [1:0] {
    OP_ADD32 = 2'd0,
    OP_SUB32 = 2'd1,
    OP_ADD64 = 2'd2,
    OP_SUB64 = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_sub(input op_e op);
    return op[0];
  endfunction

  function automatic logic is_wide(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/add_operand_sequencer_if.sv
// Command, adder and result signals of the operand sequencer.
// The slave modport is the sequencer itself; master is whatever drives commands and hosts the adder.
interface add_seq_if #(
  parameter int W  = 32,
  parameter int NW = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [NW*W-1:0]   cmd_a;
  logic [NW*W-1:0]   cmd_b;
  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_cin;
  logic [W-1:0]      add_sum;
  logic              add_ovf;
  logic              res_valid;
  logic              res_ready;
  logic [NW*W-1:0]   res_data;
  logic              res_carry;
  logic              res_ovf;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    output cmd_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_ovf,
    output res_valid, res_data, res_carry, res_ovf,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    input  cmd_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_ovf,
    input  res_valid, res_data, res_carry, res_ovf,
    output res_ready
  );
endinterface

// File: rtl/add_operand_sequencer_carry_recover.sv
// Rebuilds the carry-out of a word add from the operand and sum MSBs, since the adder does not export it.
module carry_recover (
  input  logic a_msb,
  input  logic b_msb,
  input  logic sum_msb,
  output logic cout
);
  // Both MSBs set always carry; exactly one set carries only if the lower bits carried into the MSB (sum MSB cleared).
  assign cout = (a_msb & b_msb) | ((a_msb | b_msb) & ~sum_msb);
endmodule

// File: rtl/add_operand_sequencer.sv
// Issues 32/64-bit ADD/SUB commands to an external 32-bit adder one word per cycle,
// chaining the recovered carry between words and returning the assembled result.
module add_operand_sequencer
  import add_seq_pkg::*;
#(
  parameter int W  = add_seq_pkg::W,
  parameter int NW = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  add_seq_if.slave  bus
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [NW*W-1:0]   a_q, a_d;
  logic [NW*W-1:0]   b_q, b_d;
  logic [NW*W-1:0]   res_data_q, res_data_d;
  logic              res_carry_q, res_carry_d;
  logic              res_ovf_q, res_ovf_d;
  logic              c_lo_q, c_lo_d;

  logic [W-1:0]      word_a;
  logic [W-1:0]      word_b;
  logic              word_cin;
  logic              word_cout;

  carry_recover u_carry_recover (
    .a_msb   (word_a[W-1]),
    .b_msb   (word_b[W-1]),
    .sum_msb (bus.add_sum[W-1]),
    .cout    (word_cout)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_ovf_d   = res_ovf_q;
    c_lo_d      = c_lo_q;
    word_a      = '0;
    word_b      = '0;
    word_cin    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = op_e'(bus.cmd_op);
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          state_d = LO;
        end
      end
      LO: begin
        word_a   = a_q[W-1:0];
        word_b   = is_sub(op_q) ? ~b_q[W-1:0] : b_q[W-1:0];
        word_cin = is_sub(op_q);
        res_data_d[W-1:0] = bus.add_sum;
        if (is_wide(op_q)) begin
          c_lo_d  = word_cout;
          state_d = HI;
        end else begin
          res_data_d[NW*W-1:W] = '0;
          res_carry_d          = word_cout;
          res_ovf_d            = bus.add_ovf;
          state_d              = DONE;
        end
      end
      HI: begin
        // Subtract is a + ~b + 1: the +1 entered at the low word, so the high word only sees the chained carry.
        word_a   = a_q[NW*W-1:W];
        word_b   = is_sub(op_q) ? ~b_q[NW*W-1:W] : b_q[NW*W-1:W];
        word_cin = c_lo_q;
        res_data_d[NW*W-1:W] = bus.add_sum;
        res_carry_d          = word_cout;
        res_ovf_d            = bus.add_ovf;
        state_d              = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD32;
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      c_lo_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_ovf_q   <= res_ovf_d;
      c_lo_q      <= c_lo_d;
    end
  end

  assign bus.add_a     = word_a;
  assign bus.add_b     = word_b;
  assign bus.add_cin   = word_cin;
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_data_q;
  assign bus.res_carry = res_carry_q;
  assign bus.res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_add_operand_sequencer.sv
// Directed bench for add_operand_sequencer with a behavioural 32-bit adder on the add_* ports.
module tb_add_operand_sequencer;

  logic clk;
  logic rst_n;

  add_seq_if #(.W(32), .NW(2)) bus ();

  add_operand_sequencer #(.W(32), .NW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stand-in for the CLA adder: modulo-2^32 sum and two's-complement overflow.
  assign bus.add_sum = bus.add_a + bus.add_b + {31'b0, bus.add_cin};
  assign bus.add_ovf = (bus.add_a[31] == bus.add_b[31]) && (bus.add_sum[31] != bus.add_a[31]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_data;
    logic        exp_carry;
    logic        exp_ovf;
    int          exp_lat;
    logic [31:0] exp_lo_a;
    logic [31:0] exp_lo_b;
    logic        exp_lo_cin;
    logic        exp_hi_cin;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one command, then wait (bounded) for the result and take it.
  task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic [31:0] lo_a, output logic [31:0] lo_b,
                        output logic lo_cin, output logic hi_cin, output logic [63:0] data,
                        output logic carry, output logic ovf);
    lat = -1; lo_a = '0; lo_b = '0; lo_cin = 1'b0; hi_cin = 1'b0;
    data = '0; carry = 1'b0; ovf = 1'b0;
    @(negedge clk);
    chk("cmd_ready_before_accept", {63'b0, bus.cmd_ready}, 64'd1);
    bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0; bus.cmd_a = ~a; bus.cmd_b = ~b; bus.cmd_op = ~op;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin lo_a = bus.add_a; lo_b = bus.add_b; lo_cin = bus.add_cin; end
      if (c == 2) hi_cin = bus.add_cin;
      if (bus.res_valid) begin
        lat = c; data = bus.res_data; carry = bus.res_carry; ovf = bus.res_ovf;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL res_valid_timeout: got no result within 10 cycles, expected one");
    end else begin
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
    end
  endtask

  int          lat;
  logic [31:0] lo_a, lo_b;
  logic        lo_cin, hi_cin, carry, ovf;
  logic [63:0] data;

  initial begin
    n_cmp = 0; n_fail = 0;
    //         op    a                       b                       data                    c     v     lat lo_a          lo_b          lcin  hcin
    vecs[0] = '{2'd0, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_8000_0000, 1'b0, 1'b1, 2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vecs[1] = '{2'd1, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 64'h0000_0000_FFFF_FFFE, 1'b0, 1'b0, 2, 32'h0000_0005, 32'hFFFF_FFF8, 1'b1, 1'b0};
    vecs[2] = '{2'd2, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1};
    vecs[3] = '{2'd3, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 3, 32'h0000_0000, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[4] = '{2'd3, 64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 3, 32'h0000_0000, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[5] = '{2'd0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6] = '{2'd1, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0002, 1'b1, 1'b0, 2, 32'h0000_0007, 32'hFFFF_FFFA, 1'b1, 1'b0};
    vecs[7] = '{2'd0, 64'hDEAD_BEEF_0000_0003, 64'hFFFF_FFFF_0000_0004, 64'h0000_0000_0000_0007, 1'b0, 1'b0, 2, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0};
    vecs[8] = '{2'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1};
    vecs[9] = '{2'd1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0001, 64'h0000_0000_7FFF_FFFF, 1'b1, 1'b1, 2, 32'h8000_0000, 32'hFFFF_FFFE, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {63'b0, bus.cmd_ready}, 64'd1);
    chk("rst_res_valid", {63'b0, bus.res_valid}, 64'd0);
    chk("rst_res_data", bus.res_data, 64'd0);
    chk("rst_res_carry", {63'b0, bus.res_carry}, 64'd0);
    chk("rst_res_ovf", {63'b0, bus.res_ovf}, 64'd0);
    chk("rst_add_a", {32'b0, bus.add_a}, 64'd0);
    chk("rst_add_b", {32'b0, bus.add_b}, 64'd0);
    chk("rst_add_cin", {63'b0, bus.add_cin}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, lo_a, lo_b, lo_cin, hi_cin, data, carry, ovf);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("v%0d_res_data", i), data, vecs[i].exp_data);
      chk($sformatf("v%0d_res_carry", i), {63'b0, carry}, {63'b0, vecs[i].exp_carry});
      chk($sformatf("v%0d_res_ovf", i), {63'b0, ovf}, {63'b0, vecs[i].exp_ovf});
      chk($sformatf("v%0d_lo_add_a", i), {32'b0, lo_a}, {32'b0, vecs[i].exp_lo_a});
      chk($sformatf("v%0d_lo_add_b", i), {32'b0, lo_b}, {32'b0, vecs[i].exp_lo_b});
      chk($sformatf("v%0d_lo_add_cin", i), {63'b0, lo_cin}, {63'b0, vecs[i].exp_lo_cin});
      if (vecs[i].op[1])
        chk($sformatf("v%0d_hi_add_cin", i), {63'b0, hi_cin}, {63'b0, vecs[i].exp_hi_cin});
    end

    // Backpressure: ADD32 3+4 held in DONE for 5 cycles with a stray command pulse.
    @(negedge clk);
    bus.cmd_op = 2'd0; bus.cmd_a = 64'd3; bus.cmd_b = 64'd4; bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid_cycle2", {63'b0, bus.res_valid}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      bus.cmd_valid = (k == 2);
      bus.cmd_a = 64'd100; bus.cmd_b = 64'd100;
      @(negedge clk);
      chk($sformatf("bp_res_valid_%0d", k), {63'b0, bus.res_valid}, 64'd1);
      chk($sformatf("bp_res_data_%0d", k), bus.res_data, 64'd7);
      chk($sformatf("bp_cmd_ready_%0d", k), {63'b0, bus.cmd_ready}, 64'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_res_valid", {63'b0, bus.res_valid}, 64'd0);
    chk("bp_release_cmd_ready", {63'b0, bus.cmd_ready}, 64'd1);
    repeat (3) @(negedge clk);
    chk("bp_stray_cmd_ignored", {63'b0, bus.res_valid}, 64'd0);

    // Reset during the HI pass of an ADD64.
    @(negedge clk);
    bus.cmd_op = 2'd2; bus.cmd_a = 64'h1234_5678_FFFF_FFFF; bus.cmd_b = 64'h1111_1111_0000_0001;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_in_hi_cin", {63'b0, bus.add_cin}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_res_valid", {63'b0, bus.res_valid}, 64'd0);
    chk("mid_rst_res_data", bus.res_data, 64'd0);
    chk("mid_rst_cmd_ready", {63'b0, bus.cmd_ready}, 64'd1);
    chk("mid_rst_add_a", {32'b0, bus.add_a}, 64'd0);
    run_op(2'd0, 64'd1, 64'd1, lat, lo_a, lo_b, lo_cin, hi_cin, data, carry, ovf);
    chk("post_rst_latency", 64'(lat), 64'd2);
    chk("post_rst_res_data", data, 64'd2);
    chk("post_rst_res_carry", {63'b0, carry}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
